// File: rtl/otsu_thresh_eval.sv
// Otsu arg-max evaluator: sigma = n1q*n2q*|mu1-mu2|^2, accepts one candidate per 7 cycles (in_ready only in IDLE).
// frame_done publishes the winning index next cycle; OTSU_SIGMA_OUT_EN adds the sigma_best debug output.
module otsu_thresh_eval #(
  parameter int GRAY_BITS = 7,
  parameter int CNT_W     = 20,
  parameter int SUM_W     = 23,
  parameter int N_SHIFT   = 4,
  parameter int DIFF_W    = GRAY_BITS + N_SHIFT,
  parameter int SIG_W     = 2*(CNT_W-N_SHIFT) + 2*(GRAY_BITS+N_SHIFT)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CNT_W-1:0]     n1,
  input  logic [CNT_W-1:0]     n2,
  input  logic [SUM_W-1:0]     ga1,
  input  logic [SUM_W-1:0]     ga2,
  input  logic                 frame_done,
  output logic [GRAY_BITS-1:0] t_otsu,
  output logic                 t_vld,
  output logic                 cand_ovf
`ifdef OTSU_SIGMA_OUT_EN
  ,
  output logic [SIG_W-1:0]     sigma_best
`endif
);

  localparam int NQ_W = CNT_W - N_SHIFT;
  localparam logic [SUM_W-1:0] D_SAT = SUM_W'((1 << DIFF_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_DIV1, S_DIV2, S_SUB, S_SQR, S_MUL, S_CMP} state_t;

  state_t st, st_nxt;

  logic [NQ_W-1:0]      n1q, n2q;
  logic [SUM_W-1:0]     ga1_r, ga2_r;
  logic [GRAY_BITS-1:0] idx_r, cand_idx, best_idx;
  logic [SUM_W-1:0]     mu1, mu2, d_full;
  logic [2*NQ_W-1:0]    w;
  logic [DIFF_W-1:0]    d;
  logic [2*DIFF_W-1:0]  d2;
  logic [SIG_W-1:0]     sigma, sigma_max;
  logic                 wrapped;
  logic                 accept;

  assign in_ready = (st == S_IDLE);
  // frame_done takes priority over a coincident accept
  assign accept   = in_valid & in_ready & ~frame_done;
  assign d_full   = (mu1 > mu2) ? (mu1 - mu2) : (mu2 - mu1);

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: if (accept) st_nxt = S_DIV1;
      S_DIV1: st_nxt = S_DIV2;
      S_DIV2: st_nxt = S_SUB;
      S_SUB:  st_nxt = S_SQR;
      S_SQR:  st_nxt = S_MUL;
      S_MUL:  st_nxt = S_CMP;
      S_CMP:  st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
    if (frame_done) st_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      n1q       <= '0;
      n2q       <= '0;
      ga1_r     <= '0;
      ga2_r     <= '0;
      idx_r     <= '0;
      cand_idx  <= '0;
      best_idx  <= '0;
      mu1       <= '0;
      mu2       <= '0;
      w         <= '0;
      d         <= '0;
      d2        <= '0;
      sigma     <= '0;
      sigma_max <= '0;
      wrapped   <= 1'b0;
      cand_ovf  <= 1'b0;
      t_otsu    <= '0;
      t_vld     <= 1'b0;
`ifdef OTSU_SIGMA_OUT_EN
      sigma_best <= '0;
`endif
    end else begin
      t_vld <= 1'b0;
      case (st)
        S_IDLE: if (accept) begin
          n1q   <= NQ_W'(n1 >> N_SHIFT);
          n2q   <= NQ_W'(n2 >> N_SHIFT);
          ga1_r <= ga1;
          ga2_r <= ga2;
          idx_r <= cand_idx;
          if (wrapped) cand_ovf <= 1'b1;
        end
        S_DIV1: mu1 <= (n1q == '0) ? '0 : ga1_r / SUM_W'(n1q);
        S_DIV2: begin
          mu2 <= (n2q == '0) ? '0 : ga2_r / SUM_W'(n2q);
          w   <= (2*NQ_W)'(n1q) * (2*NQ_W)'(n2q);
        end
        S_SUB:  d     <= (d_full > D_SAT) ? D_SAT[DIFF_W-1:0] : d_full[DIFF_W-1:0];
        S_SQR:  d2    <= (2*DIFF_W)'(d) * (2*DIFF_W)'(d);
        S_MUL:  sigma <= SIG_W'(w) * SIG_W'(d2);
        S_CMP: begin
          if (sigma > sigma_max) begin
            sigma_max <= sigma;
            best_idx  <= idx_r;
          end
          cand_idx <= cand_idx + 1'b1;
          if (cand_idx == '1) wrapped <= 1'b1;
        end
        default: ;
      endcase
      // Written last so it overrides any in-flight compare on the same edge
      if (frame_done) begin
        t_otsu    <= best_idx;
        t_vld     <= 1'b1;
        sigma_max <= '0;
        best_idx  <= '0;
        cand_idx  <= '0;
        wrapped   <= 1'b0;
        cand_ovf  <= 1'b0;
`ifdef OTSU_SIGMA_OUT_EN
        sigma_best <= sigma_max;
`endif
      end
    end
  end

endmodule

// File: tb/tb_otsu_thresh_eval.sv
// Directed bench for otsu_thresh_eval: table of two-candidate frames plus hand-written frame sequences.
module tb_otsu_thresh_eval;
  localparam int GB   = 7;
  localparam int CW   = 20;
  localparam int SW   = 23;
  localparam int SIGW = 54;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] n1, n2;
  logic [SW-1:0] ga1, ga2;
  logic          frame_done;
  logic [GB-1:0] t_otsu;
  logic          t_vld;
  logic          cand_ovf;
`ifdef OTSU_SIGMA_OUT_EN
  logic [SIGW-1:0] sigma_best;
`endif

  always #5 clock = ~clock;

  otsu_thresh_eval dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .n1(n1), .n2(n2), .ga1(ga1), .ga2(ga2), .frame_done(frame_done),
    .t_otsu(t_otsu), .t_vld(t_vld), .cand_ovf(cand_ovf)
`ifdef OTSU_SIGMA_OUT_EN
    , .sigma_best(sigma_best)
`endif
  );

  typedef struct {
    logic [CW-1:0]   n1;
    logic [CW-1:0]   n2;
    logic [SW-1:0]   ga1;
    logic [SW-1:0]   ga2;
    logic [GB-1:0]   exp_t;
    logic [SIGW-1:0] exp_sb;
  } vec_t;

  vec_t tbl [11];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [CW-1:0] a, input logic [CW-1:0] b,
                      input logic [SW-1:0] c, input logic [SW-1:0] e);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clock); k++; end
    chk("send_ready", in_ready, 1);
    n1 = a; n2 = b; ga1 = c; ga2 = e;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_zero();
    send(20'h1000, 20'h1000, 23'h1000, 23'h1000);
  endtask

  task automatic send_big();
    send(20'h1000, 20'h1000, 23'h1000, 23'h3000);
  endtask

  task automatic send_small();
    send(20'h1000, 20'h1000, 23'h1000, 23'h1400);
  endtask

  task automatic finish_frame(input string name, input logic [GB-1:0] exp_t);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clock); k++; end
    chk({name, "_idle"}, in_ready, 1);
    chk({name, "_tvld_pre"}, t_vld, 0);
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
    chk({name, "_tvld"}, t_vld, 1);
    chk({name, "_totsu"}, t_otsu, exp_t);
    @(negedge clock);
    chk({name, "_tvld_off"}, t_vld, 0);
  endtask

  initial begin
    // Reference candidate sigma = 65536*4^2 = 1048576
    tbl[0]  = '{20'h1000, 20'h1000, 23'h1000,   23'h3000, 7'd1, 54'd67108864};
    tbl[1]  = '{20'h1000, 20'h1000, 23'h1000,   23'h1400, 7'd0, 54'd1048576};
    tbl[2]  = '{20'h0,    20'h1000, 23'd500,    23'h3000, 7'd0, 54'd1048576};
    tbl[3]  = '{20'h0,    20'h0,    23'h1000,   23'h3000, 7'd0, 54'd1048576};
    tbl[4]  = '{20'h10,   20'h1000, 23'h7FFFFF, 23'h0,    7'd1, 54'd1072693504};
    tbl[5]  = '{20'h10,   20'h1000, 23'h400000, 23'h0,    7'd1, 54'd1072693504};
    tbl[6]  = '{20'h1000, 20'h1000, 23'h1000,   23'h1300, 7'd0, 54'd1048576};
    tbl[7]  = '{20'h100F, 20'h100F, 23'h1000,   23'h1400, 7'd0, 54'd1048576};
    tbl[8]  = '{20'h800,  20'h2000, 23'h1000,   23'h1000, 7'd1, 54'd37748736};
    tbl[9]  = '{20'h30,   20'h10,   23'd10,     23'h0,    7'd0, 54'd1048576};
    tbl[10] = '{20'h10,   20'h1000, 23'h7FFFFF, 23'h0,    7'd1, 54'd1072693504};

    rst_n = 1'b0; in_valid = 1'b0; frame_done = 1'b0;
    n1 = '0; n2 = '0; ga1 = '0; ga2 = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_t_otsu", t_otsu, 0);
    chk("rst_t_vld", t_vld, 0);
    chk("rst_cand_ovf", cand_ovf, 0);
`ifdef OTSU_SIGMA_OUT_EN
    chk("rst_sigma_best", sigma_best, 0);
`endif
    @(negedge clock); @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    // Full frame, only index 37 nonzero; measure busy window on the first accept
    begin
      int c;
      send_zero();
      chk("busy_after_accept", in_ready, 0);
      c = 0;
      while (!in_ready && c < 20) begin @(negedge clock); c++; end
      chk("accept_period", c + 1, 7);
      for (int i = 1; i < 128; i++) begin
        if (i == 37) send_big(); else send_zero();
      end
      chk("ovf_at_128", cand_ovf, 0);
      finish_frame("hot37", 7'd37);
    end

    // Tie between indices 10 and 90: lower index wins
    for (int i = 0; i < 128; i++) begin
      if (i == 10 || i == 90) send_big(); else send_zero();
    end
    finish_frame("tie10_90", 7'd10);

    // All-zero frame after a nonzero result publishes 0
    for (int i = 0; i < 4; i++) send(20'h0, 20'h0, 23'd500, 23'd700);
    finish_frame("all_zero", 7'd0);

    // Table: reference at index 0, vector at index 1
    for (int v = 0; v < 11; v++) begin
      send_small();
      send(tbl[v].n1, tbl[v].n2, tbl[v].ga1, tbl[v].ga2);
      finish_frame($sformatf("vec%0d", v), tbl[v].exp_t);
`ifdef OTSU_SIGMA_OUT_EN
      chk($sformatf("vec%0d_sigma_best", v), sigma_best, tbl[v].exp_sb);
`endif
    end

    // Abort in SQR of index 5, which would have been the max
    for (int i = 0; i < 5; i++) begin
      if (i == 2) send_small(); else send_zero();
    end
    send_big();
    repeat (3) @(negedge clock);
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
    chk("abort_tvld", t_vld, 1);
    chk("abort_totsu", t_otsu, 2);
    chk("abort_idle", in_ready, 1);
    @(negedge clock);
    chk("abort_tvld_off", t_vld, 0);
    send_zero(); send_big(); send_zero();
    finish_frame("after_abort", 7'd1);

    // 129 candidates: cand_ovf rises on the 129th accept, clears on frame_done
    for (int i = 0; i < 128; i++) send_zero();
    chk("ovf_before_129", cand_ovf, 0);
    send_small();
    chk("ovf_at_129", cand_ovf, 1);
    finish_frame("ovf_frame", 7'd0);
    chk("ovf_cleared", cand_ovf, 0);

    // frame_done coincident with an accept drops the candidate
    n1 = 20'h1000; n2 = 20'h1000; ga1 = 23'h1000; ga2 = 23'h3000;
    in_valid = 1'b1; frame_done = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; frame_done = 1'b0;
    chk("coinc_dropped", in_ready, 1);
    chk("coinc_tvld", t_vld, 1);
    chk("coinc_totsu", t_otsu, 0);
    send_zero(); send_big();
    finish_frame("after_coinc", 7'd1);

    // Reset mid-computation
    send_big();
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_t_otsu", t_otsu, 0);
    chk("midrst_t_vld", t_vld, 0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    send_zero(); send_zero(); send_big();
    finish_frame("after_rst", 7'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end
endmodule
